core_mem_responder: RTL

- Slave-side endpoint of the core's memory request interface (mem_start / mem_addr / mem_write / mem_user / mem_data_wr / mem_data_be -> mem_ready / mem_fault / mem_data_rd).
- Accepts one word-granular request from the core control unit, checks privilege, and runs the matching single Avalon-MM transaction on the system bus.
- Returns completion, read data or fault to the core, and bounds every bus access with a timeout.

---
 rtl/core_mem_responder_pkg.sv | 25 ++
 rtl/core_mem_timeout.sv | 40 ++++
 rtl/core_mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/core_mem_responder_pkg.sv
// Shared types for the core memory responder: pointer/word types, FSM states and the
// latched request record.
package core_mem_responder_pkg;

    localparam int unsigned PtrWidth  = 30;
    localparam int unsigned WordWidth = 32;

    typedef logic [PtrWidth-1:0]  ptr_t;
    typedef logic [WordWidth-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } mem_resp_state_e;

    typedef struct packed {
        ptr_t       addr;
        logic       write;
        logic       user;
        word_t      data;
        logic [3:0] be;
    } mem_request_t;

endpackage

// File: rtl/core_mem_timeout.sv
// Loadable saturating down-counter bounding a bus access; expired is high once the
// count has reached zero.
module core_mem_timeout #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntWidth-1:0] LoadVal = CntWidth'(TIMEOUT - 1);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = LoadVal;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/core_mem_responder.sv
// Slave endpoint of the core memory request interface: privilege check, one Avalon-MM
// transaction per request, and a bounded wait for the slave.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter ptr_t        USER_BASE = 30'h0400_0000,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_start,
    input  logic [29:0] mem_addr,
    input  logic        mem_write,
    input  logic        mem_user,
    input  logic [31:0] mem_data_wr,
    input  logic [3:0]  mem_data_be,
    output logic        mem_ready,
    output logic        mem_fault,
    output logic [31:0] mem_data_rd,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata
);

    mem_resp_state_e state_q, state_d;
    mem_request_t    req_q, req_d;
    logic            priv_fault_q, priv_fault_d;
    word_t           rd_q, rd_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic            tmo_clear, tmo_load, tmo_enable, tmo_expired;

    core_mem_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .load   (tmo_load),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        priv_fault_d = priv_fault_q;
        rd_d         = rd_q;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        tmo_clear    = 1'b0;
        tmo_load     = 1'b0;
        tmo_enable   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_start) begin
                    req_d.addr   = mem_addr;
                    req_d.write  = mem_write;
                    req_d.user   = mem_user;
                    req_d.data   = mem_data_wr;
                    req_d.be     = mem_write ? mem_data_be : 4'hF;
                    // Privilege faults spend one strobe-less cycle in StBus so every
                    // response has the same two-cycle minimum latency.
                    priv_fault_d = mem_user && (mem_addr < USER_BASE);
                    tmo_load     = 1'b1;
                    state_d      = StBus;
                end
            end
            StBus: begin
                if (priv_fault_q) begin
                    ready_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = StDone;
                end else if (!avl_waitrequest) begin
                    ready_d = 1'b1;
                    if (!req_q.write) begin
                        rd_d = avl_readdata;
                    end
                    state_d = StDone;
                end else if (tmo_expired) begin
                    ready_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = StDone;
                end else begin
                    tmo_enable = 1'b1;
                end
            end
            StDone: begin
                tmo_clear = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_q        <= '0;
            priv_fault_q <= 1'b0;
            rd_q         <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            priv_fault_q <= priv_fault_d;
            rd_q         <= rd_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_ready      = ready_q;
    assign mem_fault      = fault_q;
    assign mem_data_rd    = rd_q;
    assign avl_address    = {req_q.addr, 2'b00};
    assign avl_writedata  = req_q.data;
    assign avl_byteenable = req_q.be;
    assign avl_read       = (state_q == StBus) && !priv_fault_q && !req_q.write;
    assign avl_write      = (state_q == StBus) && !priv_fault_q && req_q.write;

endmodule
